// File: rtl/axis_interpolator.sv
// AXI4-Stream upsampler: every accepted sample becomes 2^L output beats,
// either repeated (hold) or ramped linearly towards the following sample.
module axis_interpolator #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int MAX_LOG_FACTOR   = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [4:0]                  log_factor,
    input  logic                        mode,
    input  logic                        S_AXIS_tvalid,
    output logic                        S_AXIS_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic [1:0]                  fsm_state
);

    localparam int W  = AXIS_TDATA_WIDTH;
    localparam int DW = AXIS_TDATA_WIDTH + 1;
    localparam int AW = AXIS_TDATA_WIDTH + 1 + MAX_LOG_FACTOR;
    localparam int CW = MAX_LOG_FACTOR;
    localparam logic [CW-1:0] CNT_ONES = '1;
    localparam logic [4:0]    L_MAX    = 5'(MAX_LOG_FACTOR);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                 linear;
    logic [4:0]           l_q;
    logic [4:0]           l_new;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_last;
    logic [W-1:0]         cur;
    logic [W-1:0]         nxt;
    logic [DW-1:0]        delta;
    logic signed [AW-1:0] acc;
    logic                 m_valid;
    logic [W-1:0]         m_data;
    logic                 s_ready;

    logic                 accept;
    logic                 beat;
    logic                 last;
    logic [W-1:0]         seg_base;
    logic [DW-1:0]        seg_delta;
    logic signed [AW-1:0] seg_acc;
    logic signed [AW-1:0] acc_inc;

    // Valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; once M_AXIS_tvalid rises, tdata/tvalid hold until taken.
    assign accept = S_AXIS_tvalid & s_ready;
    assign beat   = m_valid & M_AXIS_tready;

    assign l_new    = (log_factor > L_MAX) ? L_MAX : log_factor;
    assign cnt_last = ~(CNT_ONES << l_q);
    assign last     = (cnt == cnt_last);

    // A new linear segment starts from cur when leaving WAIT, from nxt when
    // chaining directly off the last beat of the previous segment.
    assign seg_base  = (state == ST_WAIT) ? cur : nxt;
    assign seg_delta = {S_AXIS_tdata[W-1], S_AXIS_tdata} - {seg_base[W-1], seg_base};
    assign seg_acc   = {{(AW-W){seg_base[W-1]}}, seg_base} << l_new;
    assign acc_inc   = acc + {{(AW-DW){delta[DW-1]}}, delta};

    assign S_AXIS_tready = s_ready;
    assign M_AXIS_tvalid = m_valid;
    assign M_AXIS_tdata  = m_data;
    assign fsm_state     = state;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        case (state)
            ST_EMPTY: begin
                s_ready = 1'b1;
                if (S_AXIS_tvalid) begin
                    state_next = linear ? ST_WAIT : ST_RUN;
                end
            end
            ST_WAIT: begin
                s_ready = 1'b1;
                if (S_AXIS_tvalid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                s_ready = M_AXIS_tready & last;
                if (beat && last && !S_AXIS_tvalid) begin
                    state_next = linear ? ST_WAIT : ST_EMPTY;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
        if (areset) begin
            s_ready = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            linear  <= mode;
            l_q     <= '0;
            cnt     <= '0;
            cur     <= '0;
            nxt     <= '0;
            delta   <= '0;
            acc     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        cur <= S_AXIS_tdata;
                        l_q <= l_new;
                        cnt <= '0;
                        if (!linear) begin
                            m_valid <= 1'b1;
                            m_data  <= S_AXIS_tdata;
                        end
                    end
                end
                ST_WAIT: begin
                    if (accept) begin
                        nxt     <= S_AXIS_tdata;
                        delta   <= seg_delta;
                        acc     <= seg_acc;
                        l_q     <= l_new;
                        cnt     <= '0;
                        m_valid <= 1'b1;
                        m_data  <= cur;
                    end
                end
                ST_RUN: begin
                    if (beat && !last) begin
                        cnt <= cnt + CW'(1);
                        if (linear) begin
                            acc    <= acc_inc;
                            m_data <= W'(acc_inc >>> l_q);
                        end
                    end else if (beat) begin
                        cnt <= '0;
                        if (linear) begin
                            cur <= nxt;
                        end
                        if (accept) begin
                            l_q <= l_new;
                            if (linear) begin
                                nxt    <= S_AXIS_tdata;
                                delta  <= seg_delta;
                                acc    <= seg_acc;
                                m_data <= nxt;
                            end else begin
                                cur    <= S_AXIS_tdata;
                                m_data <= S_AXIS_tdata;
                            end
                        end else begin
                            m_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/axis_interpolator.md
Name: axis_interpolator

Overview:
- AXI4-Stream upsampler: each accepted input sample produces 2^log_factor output beats.
- Two modes: zero-order hold (repeat the sample) or linear interpolation between consecutive samples.
- Sits on the playback/excitation path, feeding DAC-rate consumers from a slower sample source.
- Counterpart of the decimating throttler on the acquisition path.

Parameters:
- AXIS_TDATA_WIDTH, 32, sample width; two's-complement signed.
- MAX_LOG_FACTOR, 16, largest honoured log_factor; larger requests are clamped to this value.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- log_factor  in  5  upsampling exponent; N = 2^min(log_factor, MAX_LOG_FACTOR)
- mode  in  1  0 = hold, 1 = linear; captured only while areset=1
- S_AXIS_tvalid  in  1  input sample valid
- S_AXIS_tready  out  1  input ready
- S_AXIS_tdata  in  AXIS_TDATA_WIDTH  input sample
- M_AXIS_tvalid  out  1  output valid
- M_AXIS_tready  in  1  downstream ready
- M_AXIS_tdata  out  AXIS_TDATA_WIDTH  output sample, registered

Behaviour:
- Reset:
  - state=EMPTY; M_AXIS_tvalid=0; M_AXIS_tdata=0; cnt=0; acc=0.
  - S_AXIS_tready=0 while areset=1.
  - mode is latched every cycle areset=1 and frozen afterwards.
  - Reset mid-segment discards all held data; no partial segment completes.
- Accept/beat definitions:
  - Input accept = S_AXIS_tvalid & S_AXIS_tready.
  - Output beat = M_AXIS_tvalid & M_AXIS_tready.
- Segment start: L = clamped log_factor is latched. Changing log_factor mid-segment has no effect until the next segment.
- States: EMPTY, WAIT (linear only), RUN.
- S_AXIS_tready:
  - 1 in EMPTY and WAIT.
  - In RUN: 1 only when cnt==N-1 & M_AXIS_tready (combinational from M_AXIS_tready). Back-to-back segments therefore run with no bubble.
- Hold mode:
  - EMPTY + accept(x) -> RUN; cur=x, cnt=0, M_AXIS_tdata=x and M_AXIS_tvalid=1 from the next cycle (latency 1).
  - RUN, output beat with cnt<N-1: cnt++.
  - RUN, output beat with cnt==N-1 and simultaneous accept(y): stays in RUN; cur=y, cnt=0, new L latched.
  - RUN, output beat with cnt==N-1 and no accept: -> EMPTY, M_AXIS_tvalid=0.
- Linear mode:
  - EMPTY + accept(s0) -> WAIT; cur=s0, no output.
  - WAIT + accept(s1) -> RUN; nxt=s1, delta=s1-cur, acc=cur<<L, cnt=0.
  - Output k of a segment = acc>>>L, i.e. cur + floor(k*delta/N), k=0..N-1. The first output equals cur.
  - acc += delta on each output beat.
  - Last beat (cnt==N-1): cur<=nxt. If accept(y) in the same cycle, start a new segment cur->y. Otherwise -> WAIT with M_AXIS_tvalid=0.
  - Linear mode never returns to EMPTY except via reset. The final sample is emitted only as the start of a following segment.
- Arithmetic:
  - delta is AXIS_TDATA_WIDTH+1 bits.
  - acc is AXIS_TDATA_WIDTH+1+MAX_LOG_FACTOR bits, signed.
  - Shift is arithmetic, so results floor toward -inf.
  - Output is truncated to AXIS_TDATA_WIDTH; it is always in range because it lies between cur and nxt.
- N=1 (L=0):
  - Pure pass-through with one cycle of latency and full throughput in hold mode.
  - Linear mode degenerates to outputs delayed by one sample.
- Stall: M_AXIS_tdata and M_AXIS_tvalid hold stable while M_AXIS_tvalid=1 & M_AXIS_tready=0 (AXIS rule). cnt does not advance.
- Input is never dropped. An accepted sample is always emitted as a full segment (hold) or as a segment endpoint (linear).

Test Plan:
- Hold, log_factor=2, inputs 5,9 back-to-back, M_AXIS_tready=1 -> outputs 5,5,5,5,9,9,9,9 on consecutive cycles; S_AXIS_tready high exactly on the 4th beat of each segment; then M_AXIS_tvalid=0.
- Linear, log_factor=2, inputs 0,8,4 -> outputs 0,2,4,6,8,7,6,5; then WAIT with M_AXIS_tvalid=0 and S_AXIS_tready=1.
- Linear floor check, log_factor=2, inputs 0,-1,0 -> outputs 0,-1,-1,-1 for the first segment.
- Backpressure: hold, log_factor=1, input 3, M_AXIS_tready toggled 1,0,0,1 -> M_AXIS_tdata stays 3; exactly 2 beats transferred; cnt frozen during the low cycles.
- Clamp and latch: log_factor=31 with MAX_LOG_FACTOR=4 -> 16 outputs per input. Changing log_factor to 0 mid-segment still completes 16 beats; the next segment has 1 beat.
- Reset mid-RUN: assert areset at beat 2 of an 8-beat segment -> next cycle M_AXIS_tvalid=0, S_AXIS_tready=0. After release: state EMPTY, previous sample never re-emitted, mode reflects the value held during reset.
